// File: rtl/counter_sequencer.sv
// counter_sequencer: command-driven controller for a WIDTH-bit modulo counter.
// START/STOP/PAUSE commands arrive on a valid/ready handshake. The counter runs
// 0..mod for a programmed number of periods, pulsing tick on every wrap and
// done on completion. cmd_wraps == 0 selects free-run.
// Optional feature macro: COUNT_DOWN_EN adds a cmd_dir input. With cmd_dir=1
// latched on START, the counter loads mod, counts down and reloads at 0.
module counter_sequencer #(
    parameter int WIDTH = 4,
    parameter int CYC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mod,
    input  logic [CYC_W-1:0] cmd_wraps,
`ifdef COUNT_DOWN_EN
    input  logic             cmd_dir,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic [CYC_W-1:0] wrap_cnt,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    // Opcode 2'b00 is NOP: it is accepted and simply matches none of these.
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_PAUSE = 2'b11;

    state_t           state, state_d;
    logic [WIDTH-1:0] mod_q, mod_d, count_d;
    logic [CYC_W-1:0] wraps_q, wraps_d, wrap_cnt_d;
    logic             dir_q, dir_d;
    logic             tick_d, done_d;

    logic             accept, is_start, is_stop, is_pause, load;
    logic             start_dir, at_term, last_wrap;
    logic [WIDTH-1:0] count_step, reload_val;
    logic [CYC_W-1:0] wrap_inc;

`ifdef COUNT_DOWN_EN
    assign start_dir = cmd_dir;
`else
    assign start_dir = 1'b0;
`endif

    assign cmd_ready = (state != S_DONE);
    assign busy      = (state == S_RUN) || (state == S_PAUSE);

    assign accept    = cmd_valid && cmd_ready;
    assign is_start  = accept && (cmd_op == OP_START);
    assign is_stop   = accept && (cmd_op == OP_STOP);
    assign is_pause  = accept && (cmd_op == OP_PAUSE);

    // Direction-dependent datapath: terminal value, step and reload target.
    assign at_term    = dir_q ? (count == '0) : (count == mod_q);
    assign count_step = dir_q ? (count - WIDTH'(1)) : (count + WIDTH'(1));
    assign reload_val = dir_q ? mod_q : '0;
    assign wrap_inc   = wrap_cnt + CYC_W'(1);
    // wraps_q == 0 means free-run, so wrap_cnt may roll over without finishing.
    assign last_wrap  = (wraps_q != '0) && (wrap_inc == wraps_q);

    // Next-state and next-datapath decode; a command always beats counting.
    always_comb begin
        state_d    = state;
        count_d    = count;
        wrap_cnt_d = wrap_cnt;
        mod_d      = mod_q;
        wraps_d    = wraps_q;
        dir_d      = dir_q;
        tick_d     = 1'b0;
        done_d     = 1'b0;
        load       = 1'b0;

        case (state)
            S_IDLE: begin
                if (is_start) load = 1'b1;
            end
            S_RUN: begin
                if (is_start) begin
                    load = 1'b1;
                end else if (is_stop) begin
                    state_d    = S_IDLE;
                    count_d    = '0;
                    wrap_cnt_d = '0;
                end else if (is_pause) begin
                    state_d = S_PAUSE;
                end else if (at_term) begin
                    count_d    = reload_val;
                    tick_d     = 1'b1;
                    wrap_cnt_d = wrap_inc;
                    if (last_wrap) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    count_d = count_step;
                end
            end
            S_PAUSE: begin
                if (is_start) begin
                    load = 1'b1;
                end else if (is_stop) begin
                    state_d    = S_IDLE;
                    count_d    = '0;
                    wrap_cnt_d = '0;
                end else if (is_pause) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // START from any accepting state latches fresh config and restarts.
        if (load) begin
            state_d    = S_RUN;
            mod_d      = cmd_mod;
            wraps_d    = cmd_wraps;
            dir_d      = start_dir;
            count_d    = start_dir ? cmd_mod : '0;
            wrap_cnt_d = '0;
        end
    end

    // State, config and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            count    <= '0;
            wrap_cnt <= '0;
            mod_q    <= '0;
            wraps_q  <= '0;
            dir_q    <= 1'b0;
            tick     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            count    <= count_d;
            wrap_cnt <= wrap_cnt_d;
            mod_q    <= mod_d;
            wraps_q  <= wraps_d;
            dir_q    <= dir_d;
            tick     <= tick_d;
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer. Each step pushes the expected
// post-edge outputs to a scoreboard queue, clocks once and compares.
module tb_counter_sequencer;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_PAUSE = 2'b11;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_mod;
    logic [7:0] cmd_wraps;
`ifdef COUNT_DOWN_EN
    logic       cmd_dir;
`endif
    logic [3:0] count;
    logic       tick;
    logic [7:0] wrap_cnt;
    logic       busy;
    logic       done;

    typedef struct {
        string      tag;
        logic [3:0] count;
        logic       tick;
        logic [7:0] wrap_cnt;
        logic       busy;
        logic       done;
        logic       ready;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    counter_sequencer #(.WIDTH(4), .CYC_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_mod   (cmd_mod),
        .cmd_wraps (cmd_wraps),
`ifdef COUNT_DOWN_EN
        .cmd_dir   (cmd_dir),
`endif
        .count     (count),
        .tick      (tick),
        .wrap_cnt  (wrap_cnt),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s: observed %0h expected %0h", tag, fld, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] c, input logic t, input logic [7:0] w,
                        input logic b, input logic d, input logic r);
        exp_t e;
        e.tag = tag; e.count = c; e.tick = t; e.wrap_cnt = w;
        e.busy = b; e.done = d; e.ready = r;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk(e.tag, "count",    32'(count),     32'(e.count));
        chk(e.tag, "tick",     32'(tick),      32'(e.tick));
        chk(e.tag, "wrap_cnt", 32'(wrap_cnt),  32'(e.wrap_cnt));
        chk(e.tag, "busy",     32'(busy),      32'(e.busy));
        chk(e.tag, "done",     32'(done),      32'(e.done));
        chk(e.tag, "ready",    32'(cmd_ready), 32'(e.ready));
    endtask

    task automatic cmd(input logic [1:0] op, input logic [3:0] m, input logic [7:0] w);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_mod   = m;
        cmd_wraps = w;
    endtask

    task automatic idle_bus();
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_mod = '0; cmd_wraps = '0;
`ifdef COUNT_DOWN_EN
        cmd_dir = 1'b0;
`endif
        step("reset0", 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        step("reset1", 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;

        // mod=4, two periods, then done and back to IDLE
        cmd(OP_START, 4'd4, 8'd2);
        step("t2_start", 4'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        idle_bus();
        for (int i = 1; i <= 9; i++)
            step("t2_run", 4'(i % 5), (i == 5), 8'((i >= 5) ? 1 : 0), 1'b1, 1'b0, 1'b1);
        step("t2_done", 4'd0, 1'b1, 8'd2, 1'b0, 1'b1, 1'b0);
        step("t2_idle", 4'd0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b1);

        // free-run mod=9, across one wrap, STOP at count 6
        cmd(OP_START, 4'd9, 8'd0);
        step("t3_start", 4'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        idle_bus();
        for (int i = 1; i <= 16; i++)
            step("t3_run", 4'(i % 10), (i == 10), 8'((i >= 10) ? 1 : 0), 1'b1, 1'b0, 1'b1);
        cmd(OP_STOP, 4'd0, 8'd0);
        step("t3_stop", 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        cmd(OP_PAUSE, 4'd0, 8'd0);
        step("idle_pause", 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        idle_bus();

        // mod=5, pause at 3 for four cycles, resume to 4,5,0
        cmd(OP_START, 4'd5, 8'd0);
        step("t4_start", 4'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        idle_bus();
        for (int i = 1; i <= 3; i++)
            step("t4_run", 4'(i), 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        cmd(OP_PAUSE, 4'd0, 8'd0);
        step("t4_pause", 4'd3, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        idle_bus();
        for (int i = 0; i < 3; i++)
            step("t4_hold", 4'd3, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        cmd(OP_PAUSE, 4'd0, 8'd0);
        step("t4_resume", 4'd3, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        idle_bus();
        step("t4_r4", 4'd4, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        step("t4_r5", 4'd5, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        step("t4_wrap", 4'd0, 1'b1, 8'd1, 1'b1, 1'b0, 1'b1);

        // restart from RUN with mod=0, three periods
        cmd(OP_START, 4'd0, 8'd3);
        step("t5_start", 4'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        idle_bus();
        step("t5_w1", 4'd0, 1'b1, 8'd1, 1'b1, 1'b0, 1'b1);
        step("t5_w2", 4'd0, 1'b1, 8'd2, 1'b1, 1'b0, 1'b1);
        step("t5_done", 4'd0, 1'b1, 8'd3, 1'b0, 1'b1, 1'b0);
        cmd(OP_START, 4'd2, 8'd0);
        step("done_ign", 4'd0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1);
        idle_bus();
        step("done_idle", 4'd0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1);

        // PAUSE exactly at count==mod suppresses the wrap
        cmd(OP_START, 4'd3, 8'd0);
        step("t6_start", 4'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        idle_bus();
        for (int i = 1; i <= 3; i++)
            step("t6_run", 4'(i), 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        cmd(OP_PAUSE, 4'd0, 8'd0);
        step("t6_pause", 4'd3, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        cmd(OP_PAUSE, 4'd0, 8'd0);
        step("t6_resume", 4'd3, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        idle_bus();
        step("t6_wrap", 4'd0, 1'b1, 8'd1, 1'b1, 1'b0, 1'b1);
        step("t6_after", 4'd1, 1'b0, 8'd1, 1'b1, 1'b0, 1'b1);
        cmd(OP_STOP, 4'd0, 8'd0);
        step("t6_stop", 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        idle_bus();

        // reset held two cycles in the middle of a run
        cmd(OP_START, 4'd7, 8'd0);
        step("t1_start", 4'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        idle_bus();
        for (int i = 1; i <= 3; i++)
            step("t1_run", 4'(i), 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        rst_n = 1'b0;
        step("t1_rst0", 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        step("t1_rst1", 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        step("t1_after", 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);

`ifdef COUNT_DOWN_EN
        // down-count mod=3: 3,2,1,0,3
        cmd_dir = 1'b1;
        cmd(OP_START, 4'd3, 8'd0);
        step("dn_start", 4'd3, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        idle_bus();
        cmd_dir = 1'b0;
        step("dn_2", 4'd2, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        step("dn_1", 4'd1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        step("dn_0", 4'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        step("dn_reload", 4'd3, 1'b1, 8'd1, 1'b1, 1'b0, 1'b1);
        cmd(OP_STOP, 4'd0, 8'd0);
        step("dn_stop", 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        idle_bus();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
